// File: rtl/irq_event_coalesce.sv
// Event-line synchronizer, edge/level detector and interrupt coalescer.
// Define IRQ_EVENT_COALESCE_EN to build the coalescing state machine; otherwise detections bypass straight to trig.
module irq_event_coalesce #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             bus_clk,
  input  logic             bus_reset_l,
  input  logic [WIDTH-1:0] evt_in,
  input  logic [WIDTH-1:0] edge_mode,
  input  logic [7:0]       coal_count,
  input  logic [15:0]      coal_time,
  output logic [WIDTH-1:0] trig,
  output logic             busy
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] trig_q, trig_d;
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] det;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
    sync_w = sync_q[SYNC_STAGES-1];
    prev_d = sync_w;
    // Level bits pass sync straight through; edge bits need the previous sample low.
    det    = sync_w & ~(edge_mode & prev_q);
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      sync_q <= '0;
      prev_q <= '0;
      trig_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      trig_q <= trig_d;
    end
  end

  assign trig = trig_q;

`ifdef IRQ_EVENT_COALESCE_EN

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [7:0]       evt_cnt_q, evt_cnt_d;
  logic [15:0]      timer_q, timer_d;
  logic             any_det;
  logic             bypass;
  logic [7:0]       cnt_inc;

  always_comb begin
    any_det = |det;
    bypass  = (coal_count <= 8'd1);
    cnt_inc = (any_det && (evt_cnt_q != 8'hFF)) ? evt_cnt_q + 8'd1 : evt_cnt_q;
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q   <= IDLE;
      pending_q <= '0;
      evt_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      evt_cnt_q <= evt_cnt_d;
      timer_q   <= timer_d;
    end
  end

  // A live coal_count at or below 1 also forces an open window to flush, so bypass never strands pending bits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bypass && any_det) state_d = ACCUM;
      ACCUM:   if ((cnt_inc >= coal_count) || (timer_q == 16'd0)) state_d = FLUSH;
      FLUSH:   state_d = any_det ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_d    = '0;
    pending_d = pending_q;
    evt_cnt_d = evt_cnt_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        if (bypass) begin
          trig_d = det;
        end else if (any_det) begin
          pending_d = det;
          evt_cnt_d = 8'd1;
          timer_d   = coal_time;
        end
      end
      ACCUM: begin
        pending_d = pending_q | det;
        evt_cnt_d = cnt_inc;
        timer_d   = (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
      end
      FLUSH: begin
        trig_d    = pending_q;
        pending_d = det;
        evt_cnt_d = any_det ? 8'd1 : 8'd0;
        timer_d   = any_det ? coal_time : 16'd0;
      end
      default: begin
        pending_d = '0;
        evt_cnt_d = '0;
        timer_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ACCUM) || (state_q == FLUSH);
  end

`else

  logic unused_cfg;

  always_comb begin
    trig_d     = det;
    busy       = 1'b0;
    unused_cfg = ^{coal_count, coal_time};
  end

`endif

endmodule
